aes_128_cbc_encrypt: RTL and testbench
======================================

# aes_128_cbc_encrypt

CBC-mode encryption controller for the AES-128 image pipeline; the transmit-side counterpart to `aes_128_cbc_decrypt`. It accepts 128-bit plaintext blocks over a valid/ready stream and XORs each one with the chaining value (the IV, or the previous ciphertext). It drives an external iterative AES-128 encrypt core through a start/done handshake and returns the ciphertext on a valid/ready output stream. It sits between the image block packer and the ciphertext writer.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sess_start`  in  1  one-cycle strobe; loads `iv` and `key`; honoured only in IDLE.
- `iv`  in  128  initialisation vector, sampled on an accepted `sess_start`.
- `key`  in  128  AES key, sampled on an accepted `sess_start`.
- `in_valid`  in  1  plaintext block valid.
- `in_ready`  out  1  controller can accept a block.
- `plaintext`  in  128  plaintext block.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  downstream accepts the ciphertext.
- `ciphertext`  out  128  ciphertext block, held stable while `out_valid` is high.
- `core_start`  out  1  one-cycle start pulse to the AES core.
- `core_key`  out  128  registered session key.
- `core_din`  out  128  registered value `plaintext ^ chain`.
- `core_done`  in  1  one-cycle pulse from the core; `core_dout` is valid in that cycle.
- `core_dout`  in  128  core result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - `in_ready`=1.
  - If `sess_start`=1: `chain`<=`iv`, `core_key`<=`key`, and `in_ready` is forced to 0 in that cycle. `sess_start` has priority over `in_valid`.
  - Else if `in_valid`=1: `core_din`<=`plaintext ^ chain`, then go to START.
- START: `core_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `core_done`=1, `ciphertext`<=`core_dout`, then go to OUT. `core_done` seen in any other state is ignored.
- OUT:
  - `out_valid`=1.
  - On `out_ready`=1: `chain`<=`ciphertext`, then go to IDLE.
  - `ciphertext` is held until the handshake completes. Backpressure can last any number of cycles.
- `sess_start` outside IDLE is ignored; the chain value is not modified.
- Blocks encrypted before any `sess_start` chain from the reset value of `chain` (0).
- Only one block is in flight at a time. No buffering.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1 after reset deassertion.
  - `out_valid`=0, `core_start`=0, `busy`=0.
  - `ciphertext`, `core_din`, `core_key` and `chain` all 0.
- With the block accepted in cycle N:
  - `core_start` is high in cycle N+1.
  - If `core_done` arrives in cycle D (D ≥ N+2), `out_valid` rises in cycle D+1.
- Zero-wait downstream: the next block can be accepted one cycle after the output handshake. Block period = core latency + 3 cycles.
- Reset asserted mid-operation: return immediately to the reset state. Any in-flight block is discarded. A late `core_done` after reset is ignored.

## Configuration
- `AES_CBC_ENC_BLKCNT_EN`
  - Defined: adds output `blk_cnt` [31:0]. It is cleared to 0 on reset and on an accepted `sess_start`, increments by 1 on each output handshake, and wraps from FFFFFFFF to 0.
  - Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- FIPS-197 vector:
  - Stimulus: `sess_start` with `key`=000102030405060708090a0b0c0d0e0f and `iv`=0, then `plaintext`=00112233445566778899aabbccddeeff.
  - Required: `core_din`=00112233445566778899aabbccddeeff and `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Chaining: continue the same session with `plaintext`=69d5c2eb2e2e624750541d3bbc692ba5 → `core_din`=00112233445566778899aabbccddeeff and `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles.
  - Required: `ciphertext` is stable and `in_ready`=0 throughout. The handshake then occurs in exactly one cycle.
- Session priority:
  - Stimulus: assert `sess_start` together with `in_valid` in IDLE.
  - Required: the IV is loaded and the block is not accepted (`in_ready`=0). The block is accepted in the next cycle, XORed with the new IV.
- Reset mid-WAIT:
  - Stimulus: drop `rst_n` in WAIT.
  - Required: all outputs return to their reset values. A `core_done` issued after reset produces no `out_valid`.
- With `AES_CBC_ENC_BLKCNT_EN` defined: 3 blocks → `blk_cnt`=3. A new `sess_start` → `blk_cnt`=0.

Source files
------------

// File: rtl/aes_128_cbc_encrypt.sv
// -----------------------------------------------------------------------------
// aes_128_cbc_encrypt
//
// CBC-mode encryption controller. Each accepted plaintext block is XORed with
// the chaining value (the session IV, or the previous ciphertext) and handed
// to an external iterative AES-128 encrypt core through a start/done
// handshake. The core result is returned on a valid/ready output stream and
// becomes the chaining value for the next block. Only one block is in flight
// at a time; there is no buffering.
//
// Optional feature (compile-time macro AES_CBC_ENC_BLKCNT_EN):
//   adds a 32-bit output blk_cnt counting completed output handshakes,
//   cleared on reset and on an accepted sess_start, wrapping at 2^32.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sess_start  in   session strobe; loads iv/key, honoured only in IDLE
//   iv          in   [127:0] initialisation vector
//   key         in   [127:0] AES key
//   in_valid    in   plaintext block valid
//   in_ready    out  controller can accept a block
//   plaintext   in   [127:0] plaintext block
//   out_valid   out  ciphertext valid
//   out_ready   in   downstream accepts the ciphertext
//   ciphertext  out  [127:0] ciphertext, stable while out_valid is high
//   core_start  out  one-cycle start pulse to the AES core
//   core_key    out  [127:0] registered session key
//   core_din    out  [127:0] registered plaintext ^ chain
//   core_done   in   one-cycle completion pulse from the core
//   core_dout   in   [127:0] core result, valid with core_done
//   blk_cnt     out  [31:0] output handshake count (AES_CBC_ENC_BLKCNT_EN only)
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module aes_128_cbc_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sess_start,
    input  logic [127:0] iv,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    input  logic         core_done,
    input  logic [127:0] core_dout,
`ifdef AES_CBC_ENC_BLKCNT_EN
    output logic [31:0]  blk_cnt,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // CBC pre-whitening: the block entering the cipher is plaintext ^ chain.
    function automatic logic [127:0] cbc_mix(
        input logic [127:0] blk,
        input logic [127:0] chain
    );
        return blk ^ chain;
    endfunction

    state_e       state_q,      state_d;
    logic         idle_q,       idle_d;
    logic         out_valid_q,  out_valid_d;
    logic         core_start_q, core_start_d;
    logic         busy_q,       busy_d;
    logic [127:0] ciphertext_q, ciphertext_d;
    logic [127:0] core_din_q,   core_din_d;
    logic [127:0] core_key_q,   core_key_d;
    logic [127:0] chain_q,      chain_d;
`ifdef AES_CBC_ENC_BLKCNT_EN
    logic [31:0]  blk_cnt_q,    blk_cnt_d;
`endif

    // Next-state and datapath decode for the single-block CBC sequencer.
    always_comb begin
        state_d      = state_q;
        idle_d       = idle_q;
        out_valid_d  = out_valid_q;
        core_start_d = 1'b0;
        busy_d       = busy_q;
        ciphertext_d = ciphertext_q;
        core_din_d   = core_din_q;
        core_key_d   = core_key_q;
        chain_d      = chain_q;
`ifdef AES_CBC_ENC_BLKCNT_EN
        blk_cnt_d    = blk_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A session load wins over a waiting block; the block is taken
                // next cycle and therefore chains from the freshly loaded IV.
                if (sess_start) begin
                    chain_d    = iv;
                    core_key_d = key;
`ifdef AES_CBC_ENC_BLKCNT_EN
                    blk_cnt_d  = 32'd0;
`endif
                end else if (in_valid) begin
                    core_din_d   = cbc_mix(plaintext, chain_q);
                    state_d      = ST_START;
                    core_start_d = 1'b1;
                    idle_d       = 1'b0;
                    busy_d       = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (core_done) begin
                    ciphertext_d = core_dout;
                    out_valid_d  = 1'b1;
                    state_d      = ST_OUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_OUT: begin
                // The ciphertext just delivered becomes the next chaining value.
                if (out_ready) begin
                    chain_d     = ciphertext_q;
                    out_valid_d = 1'b0;
                    idle_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
`ifdef AES_CBC_ENC_BLKCNT_EN
                    blk_cnt_d   = blk_cnt_q + 32'd1;
`endif
                end else begin
                    state_d = ST_OUT;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle handshake state.
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                idle_d      = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idle_q       <= 1'b1;
            out_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ciphertext_q <= 128'd0;
            core_din_q   <= 128'd0;
            core_key_q   <= 128'd0;
            chain_q      <= 128'd0;
`ifdef AES_CBC_ENC_BLKCNT_EN
            blk_cnt_q    <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            out_valid_q  <= out_valid_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            ciphertext_q <= ciphertext_d;
            core_din_q   <= core_din_d;
            core_key_q   <= core_key_d;
            chain_q      <= chain_d;
`ifdef AES_CBC_ENC_BLKCNT_EN
            blk_cnt_q    <= blk_cnt_d;
`endif
        end
    end

    // in_ready is the registered idle flag, masked in the cycle a session
    // strobe is being honoured so the block is not taken alongside it.
    assign in_ready   = idle_q & ~sess_start;
    assign out_valid  = out_valid_q;
    assign ciphertext = ciphertext_q;
    assign core_start = core_start_q;
    assign core_key   = core_key_q;
    assign core_din   = core_din_q;
    assign busy       = busy_q;
`ifdef AES_CBC_ENC_BLKCNT_EN
    assign blk_cnt    = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_128_cbc_encrypt.sv
// -----------------------------------------------------------------------------
// tb_aes_128_cbc_encrypt
//
// Scoreboard bench for the CBC encrypt controller. A behavioural stand-in for
// the AES core answers core_start after a programmable latency. Expected
// core_din / ciphertext values are computed from a bench-side chain model when
// a block is driven and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_aes_128_cbc_encrypt;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CHAIN_PT = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sess_start = 1'b0;
    logic [127:0] iv = 128'd0;
    logic [127:0] key = 128'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] ciphertext;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = 128'd0;
    logic         busy;
`ifdef AES_CBC_ENC_BLKCNT_EN
    logic [31:0]  blk_cnt;
`endif

    aes_128_cbc_encrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sess_start (sess_start),
        .iv         (iv),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .core_start (core_start),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout),
`ifdef AES_CBC_ENC_BLKCNT_EN
        .blk_cnt    (blk_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: the FIPS-197 known answer, otherwise a keyed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) begin
            return FIPS_CT;
        end
        return {d[94:0], d[127:95]} ^ k ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
    endfunction

    // Bench models and scoreboard queues
    logic [127:0] chain_m = 128'd0;
    logic [127:0] key_m   = 128'd0;
    int           blk_m   = 0;
    logic [127:0] din_q[$];
    logic [127:0] ct_q[$];

    // Behavioural AES core: answers core_start after core_lat cycles.
    int           core_lat = 3;
    int           core_cnt = 0;
    logic [127:0] din_cap  = 128'd0;
    logic [127:0] key_cap  = 128'd0;
    always @(posedge clk) begin
        #1;
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_dout = core_fn(din_cap, key_cap);
            end
        end
        if (core_start) begin
            core_cnt = core_lat;
            din_cap  = core_din;
            key_cap  = core_key;
        end
    end

    // Cycle counter for latency checks
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency checks and scoreboard pops, sampled mid-cycle.
    int   acc_cyc  = -100;
    int   done_cyc = -100;
    logic prev_ov  = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (core_start) begin
                chk("start_lat", 128'(cyc), 128'(acc_cyc + 1));
                chk("din_q_nonempty", 128'(din_q.size() > 0), 128'd1);
                if (din_q.size() > 0) chk("core_din", core_din, din_q.pop_front());
                chk("core_key", core_key, key_m);
            end
            if (core_done) done_cyc = cyc;
            if (out_valid && !prev_ov) chk("out_lat", 128'(cyc), 128'(done_cyc + 1));
            if (out_valid && out_ready) begin
                chk("ct_q_nonempty", 128'(ct_q.size() > 0), 128'd1);
                if (ct_q.size() > 0) chk("ciphertext", ciphertext, ct_q.pop_front());
                blk_m = blk_m + 1;
            end
        end
        prev_ov = out_valid;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},   128'(in_ready),   128'd1);
        chk({tag, "_out_valid"},  128'(out_valid),  128'd0);
        chk({tag, "_core_start"}, 128'(core_start), 128'd0);
        chk({tag, "_busy"},       128'(busy),       128'd0);
        chk({tag, "_ciphertext"}, ciphertext,       128'd0);
        chk({tag, "_core_din"},   core_din,         128'd0);
        chk({tag, "_core_key"},   core_key,         128'd0);
    endtask

    // Drive one block; expectations are pushed from the chain model first.
    task automatic send_block(input logic [127:0] pt);
        logic [127:0] d;
        int n;
        d = pt ^ chain_m;
        din_q.push_back(d);
        ct_q.push_back(core_fn(d, key_m));
        chain_m = core_fn(d, key_m);
        @(posedge clk); #1;
        plaintext = pt;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("accept", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("idle_timeout", 128'(busy), 128'd0);
    endtask

    task automatic do_sess(input logic [127:0] k, input logic [127:0] v);
        @(posedge clk); #1;
        sess_start = 1'b1;
        iv         = v;
        key        = k;
        chain_m    = v;
        key_m      = k;
        blk_m      = 0;
        @(negedge clk);
        chk("sess_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        sess_start = 1'b0;
`ifdef AES_CBC_ENC_BLKCNT_EN
        @(negedge clk);
        chk("blk_cnt_sess", 128'(blk_cnt), 128'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_ct;
        logic [127:0] pt;
        logic [127:0] nk;
        logic [127:0] niv;
        logic         seen;
        int           n;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst");

        // Block before any session chains from chain = 0 with key = 0.
        send_block(128'hdeadbeef_00000001_cafef00d_12345678);
        wait_idle();

        // FIPS-197 vector, then a chained block that XORs back to the same input.
        do_sess(FIPS_KEY, 128'd0);
        send_block(FIPS_PT);
        wait_idle();
        send_block(CHAIN_PT);
        wait_idle();
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_idle();
`ifdef AES_CBC_ENC_BLKCNT_EN
        chk("blk_cnt_3", 128'(blk_cnt), 128'd3);
`endif

        // Backpressure: out_ready low for 20 cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_block({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        exp_ct = (ct_q.size() > 0) ? ct_q[0] : 128'd0;
        repeat (20) begin
            chk("bp_ct_stable", ciphertext, exp_ct);
            chk("bp_in_ready",  128'(in_ready), 128'd0);
            chk("bp_ov_held",   128'(out_valid), 128'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_one_cycle_hs", 128'(out_valid), 128'd0);
        chk("bp_in_ready_after", 128'(in_ready), 128'd1);

        // Session priority over a simultaneous block.
        nk  = {$urandom, $urandom, $urandom, $urandom};
        niv = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        chain_m = niv;
        key_m   = nk;
        blk_m   = 0;
        din_q.push_back(pt ^ niv);
        ct_q.push_back(core_fn(pt ^ niv, nk));
        chain_m = core_fn(pt ^ niv, nk);
        @(posedge clk); #1;
        sess_start = 1'b1;
        iv         = niv;
        key        = nk;
        in_valid   = 1'b1;
        plaintext  = pt;
        @(negedge clk);
        chk("prio_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        sess_start = 1'b0;
        @(negedge clk);
        chk("prio_accept_next", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
`ifdef AES_CBC_ENC_BLKCNT_EN
        chk("blk_cnt_1", 128'(blk_cnt), 128'd1);
`endif

        // Random blocks with varying core latency.
        for (int i = 0; i < 6; i++) begin
            core_lat = $urandom_range(1, 6);
            send_block({$urandom, $urandom, $urandom, $urandom});
            wait_idle();
        end

        // Reset in WAIT; the core's late done must be ignored.
        core_lat = 8;
        send_block({$urandom, $urandom, $urandom, $urandom});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_wait_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        din_q.delete();
        ct_q.delete();
        chain_m = 128'd0;
        key_m   = 128'd0;
        blk_m   = 0;
        @(negedge clk);
        check_reset("rst_mid");
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("late_done_ignored", 128'(seen), 128'd0);

        // Chain and key restart from zero after reset.
        core_lat = 2;
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        chk("sb_drained", 128'(din_q.size() + ct_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
